// File: rtl/adc_seq_pkg.sv
// Shared state encoding and default constants for the SAR conversion sequencer.
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    localparam int DEF_RESOLUTION    = 12;
    localparam int DEF_SAMPLE_CYCLES = 8;

endpackage

// File: rtl/adc_sync_edge.sv
// Two-flop synchronizer with a history flop producing a one-cycle rise pulse.
module adc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s1;
    logic s2;
    logic hist;
    logic primed;
    logic armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            hist   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            s1     <= d;
            s2     <= s1;
            hist   <= s2;
            primed <= 1'b1;
            // a genuinely sampled low is required before any edge counts
            armed  <= armed | (primed & ~s1);
        end
    end

    assign q    = s2;
    assign rise = s2 & ~hist & armed;

endmodule

// File: rtl/adc_conv_sequencer.sv
// SAR ADC conversion sequencer: sample phase, bitwise successive approximation,
// one-cycle done strobe, optional continuous conversion.
module adc_conv_sequencer
    import adc_seq_pkg::*;
#(
    parameter int RESOLUTION    = DEF_RESOLUTION,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_conv,
    input  logic                  ena_in,
    input  logic                  abort,
    input  logic                  comp_in,
    output logic                  sample_out,
    output logic [RESOLUTION-1:0] dac_code,
    output logic [RESOLUTION-1:0] result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  ena_out
);

    localparam logic [7:0] SC_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [3:0] K_TOP   = 4'(RESOLUTION - 1);
    localparam logic [RESOLUTION-1:0] LSB = RESOLUTION'(1);
    localparam logic [RESOLUTION-1:0] MSB = {1'b1, {(RESOLUTION-1){1'b0}}};

    seq_state_t            state;
    logic [7:0]            cnt;
    logic [3:0]            k;
    logic [RESOLUTION-1:0] code;
    logic [RESOLUTION-1:0] code_next;
    logic [RESOLUTION-1:0] trial_next;
    logic                  start_edge;
    logic                  start_sync;

    adc_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (start_conv),
        .q    (start_sync),
        .rise (start_edge)
    );

    assign code_next  = code | (comp_in ? (LSB << k) : '0);
    assign trial_next = code_next | (LSB << (k - 4'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sample_out   <= 1'b0;
            dac_code     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            code         <= '0;
            cnt          <= '0;
            k            <= '0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_edge || ena_in) begin
                        state      <= SAMPLE;
                        sample_out <= 1'b1;
                        cnt        <= SC_LAST;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        sample_out <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        state      <= CONVERT;
                        sample_out <= 1'b0;
                        k          <= K_TOP;
                        code       <= '0;
                        dac_code   <= MSB;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                CONVERT: begin
                    if (abort) begin
                        state    <= IDLE;
                        dac_code <= '0;
                    end else if (k == 4'd0) begin
                        state        <= DONE;
                        code         <= code_next;
                        result       <= code_next;
                        result_valid <= 1'b1;
                        dac_code     <= '0;
                    end else begin
                        k        <= k - 4'd1;
                        code     <= code_next;
                        dac_code <= trial_next;
                    end
                end
                DONE: begin
                    // abort during DONE lets the strobe finish but stops chaining
                    if (ena_in && !abort) begin
                        state      <= SAMPLE;
                        sample_out <= 1'b1;
                        cnt        <= SC_LAST;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign ena_out = busy | ena_in;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Randomized bench for adc_conv_sequencer with an ideal-comparator SAR reference.
module tb_adc_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_conv;
    logic       ena_in;
    logic       abort;
    logic       comp_in;
    logic       sample_out;
    logic [7:0] dac_code;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic       ena_out;
    logic [7:0] vin;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_res;

    adc_conv_sequencer #(
        .RESOLUTION    (8),
        .SAMPLE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_conv   (start_conv),
        .ena_in       (ena_in),
        .abort        (abort),
        .comp_in      (comp_in),
        .sample_out   (sample_out),
        .dac_code     (dac_code),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .ena_out      (ena_out)
    );

    always #5 clk = ~clk;

    // ideal comparator: input at or above trial level
    assign comp_in = (vin >= dac_code);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // binary-search trial j: upper j bits of vin kept, next bit tried
    function automatic int trial(input int v, input int j);
        return ((v >> (8 - j)) << (8 - j)) | (128 >> j);
    endfunction

    task automatic wait_sample(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sample_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // called at the first SAMPLE cycle; leaves off one cycle after the last checked one
    task automatic run_trace(input logic [7:0] v, input int abort_at,
                             input int pulse_at);
        vin = v;
        for (int i = 0; i < 13; i++) begin
            if (i == pulse_at) start_conv = 1'b1;
            if (i == pulse_at + 3) start_conv = 1'b0;
            if (i < 4) begin
                check("samp_hi", {31'd0, sample_out}, 32'd1);
                check("samp_dac", {24'd0, dac_code}, 32'd0);
            end else if (i < 12) begin
                check("conv_samp", {31'd0, sample_out}, 32'd0);
                check("conv_dac", {24'd0, dac_code}, trial(int'(v), i - 4));
                check("conv_rv", {31'd0, result_valid}, 32'd0);
            end else begin
                check("done_rv", {31'd0, result_valid}, 32'd1);
                check("done_res", {24'd0, result}, {24'd0, v});
                check("done_dac", {24'd0, dac_code}, 32'd0);
            end
            check("busy", {31'd0, busy}, 32'd1);
            check("ena_out", {31'd0, ena_out}, 32'd1);
            if (i == abort_at) abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            if (i == abort_at) break;
        end
    endtask

    task automatic run_one(input logic [7:0] v, input int abort_at,
                           input int pulse_at);
        bit ok;
        start_conv = 1'b1;
        wait_sample(ok);
        start_conv = 1'b0;
        check("start_seen", {31'd0, ok}, 32'd1);
        if (ok) begin
            run_trace(v, abort_at, pulse_at);
            if (abort_at < 0 || abort_at >= 12) last_res = v;
            check("after_busy", {31'd0, busy}, 32'd0);
            check("after_rv", {31'd0, result_valid}, 32'd0);
            check("after_res", {24'd0, result}, {24'd0, last_res});
            check("after_dac", {24'd0, dac_code}, 32'd0);
        end
    endtask

    initial begin
        bit ok;
        int nv;
        int nb;
        rst = 1'b1;
        start_conv = 1'b0;
        ena_in = 1'b0;
        abort = 1'b0;
        vin = 8'd0;
        last_res = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_samp", {31'd0, sample_out}, 32'd0);
        check("rst_dac", {24'd0, dac_code}, 32'd0);
        check("rst_res", {24'd0, result}, 32'd0);
        check("rst_rv", {31'd0, result_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ena_out", {31'd0, ena_out}, 32'd0);
        repeat (4) @(negedge clk);

        run_one(8'hA5, -1, -1);
        run_one(8'h00, -1, -1);
        run_one(8'hFF, -1, -1);
        for (int r = 0; r < 5; r++) begin
            run_one(8'($urandom_range(0, 255)), -1, -1);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // second edge while converting must be dropped
        run_one(8'($urandom_range(0, 255)), -1, 5);
        nv = 0;
        nb = 0;
        for (int n = 0; n < 20; n++) begin
            if (result_valid) nv++;
            if (busy) nb++;
            @(negedge clk);
        end
        check("rej_rv", nv, 0);
        check("rej_busy", nb, 0);

        // continuous mode, back to back
        ena_in = 1'b1;
        wait_sample(ok);
        check("cont_start", {31'd0, ok}, 32'd1);
        if (ok) begin
            for (int n = 0; n < 3; n++) begin
                if (n == 2) ena_in = 1'b0;
                run_trace(8'(16 * (n + 1)), -1, -1);
                last_res = 8'(16 * (n + 1));
                if (n < 2) check("cont_nogap", {31'd0, sample_out}, 32'd1);
            end
            check("cont_end_busy", {31'd0, busy}, 32'd0);
            check("cont_end_ena", {31'd0, ena_out}, 32'd0);
        end
        repeat (2) @(negedge clk);

        // abort during third CONVERT cycle
        run_one(8'($urandom_range(0, 255)), 6, -1);
        nv = 0;
        for (int n = 0; n < 15; n++) begin
            if (result_valid) nv++;
            @(negedge clk);
        end
        check("abort_rv", nv, 0);
        check("abort_res", {24'd0, result}, {24'd0, last_res});

        // abort coinciding with DONE while continuous
        ena_in = 1'b1;
        wait_sample(ok);
        check("abd_start", {31'd0, ok}, 32'd1);
        if (ok) begin
            run_trace(8'h5A, 12, -1);
            last_res = 8'h5A;
            check("abd_idle", {31'd0, busy}, 32'd0);
            check("abd_res", {24'd0, result}, 32'h5A);
        end
        ena_in = 1'b0;
        repeat (3) @(negedge clk);

        // reset in SAMPLE with start held high
        start_conv = 1'b1;
        wait_sample(ok);
        check("rs_start", {31'd0, ok}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rs_samp", {31'd0, sample_out}, 32'd0);
        check("rs_dac", {24'd0, dac_code}, 32'd0);
        check("rs_res", {24'd0, result}, 32'd0);
        check("rs_rv", {31'd0, result_valid}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        last_res = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        nb = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("rs_held_nostart", nb, 0);
        start_conv = 1'b0;
        repeat (4) @(negedge clk);
        run_one(8'h3C, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
